// File: rtl/chb_pkg.sv
// Shared types and sizing for the channel word buffer: state encoding,
// word/slot geometry and a small population-count helper.
package chb_pkg;

  localparam int WORD_W = 36;
  localparam int NSLOT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } chb_state_e;

  function automatic logic [2:0] popcnt4(input logic [NSLOT-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NSLOT; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/chb_slot_sel.sv
// Lowest-set-bit priority encoder over the four slot-valid bits; selects
// the head slot presented to the channel.
module chb_slot_sel
  import chb_pkg::*;
(
  input  logic [NSLOT-1:0] vec_h,
  output logic [1:0]       idx_h,
  output logic             any_h
);

  always_comb begin
    idx_h = 2'd0;
    any_h = |vec_h;
    // Scan downward so the lowest-numbered set bit is the last to win.
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (vec_h[i]) begin
        idx_h = i[1:0];
      end
    end
  end

endmodule

// File: rtl/chb_word_buf.sv
// Four-slot channel word buffer: collects requested memory words in any
// order, then hands them to the channel lowest slot first, one per cycle.
module chb_word_buf
  import chb_pkg::*;
(
  input  logic              clk_ch_h,
  input  logic              ch_mr_reset_l,
  input  logic [NSLOT-1:0]  ccw_wd_req_h,
  input  logic [NSLOT-1:0]  mb_hold_in_h,
  input  logic [0:WORD_W-1] mb_data_h,
  input  logic              ccl_zero_fill_h,
  input  logic              chan_word_take_h,
  input  logic              chb_err_clr_h,
  output logic [0:WORD_W-1] chb_word_h,
  output logic              chb_word_valid_h,
  output logic              chb_wd_ready_l,
  output logic [2:0]        chb_count_h,
  output logic              chb_busy_h,
  output logic              chb_err_h
);

  chb_state_e        state_q, state_d;
  logic [NSLOT-1:0]  req_q, req_d;
  logic [NSLOT-1:0]  pend_q, pend_d;
  logic [NSLOT-1:0]  valid_q, valid_d;
  logic              err_q, err_d;
  logic              rdy_l_q, rdy_l_d;
  logic [0:WORD_W-1] slot_q [NSLOT];
  logic [0:WORD_W-1] slot_d [NSLOT];

  logic [0:WORD_W-1] wdata;
  logic              err_set;
  logic [1:0]        head_idx;
  logic              head_any;
  logic              drain_vld;

  chb_slot_sel u_slot_sel (
    .vec_h (valid_q),
    .idx_h (head_idx),
    .any_h (head_any)
  );

  always_ff @(posedge clk_ch_h or negedge ch_mr_reset_l) begin
    if (!ch_mr_reset_l) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      rdy_l_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdy_l_q <= rdy_l_d;
    end
  end

  // Slot payload is not reset; the output mux hides it whenever no slot is valid.
  always_ff @(posedge clk_ch_h) begin
    for (int n = 0; n < NSLOT; n++) begin
      slot_q[n] <= slot_d[n];
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    rdy_l_d = 1'b1;
    err_set = 1'b0;
    wdata   = ccl_zero_fill_h ? '0 : mb_data_h;
    for (int n = 0; n < NSLOT; n++) begin
      slot_d[n] = slot_q[n];
    end

    // A strobe for a slot that is not awaiting data is a protocol error and is dropped.
    for (int n = 0; n < NSLOT; n++) begin
      if (mb_hold_in_h[n] && !((state_q == FILL) && pend_q[n])) begin
        err_set = 1'b1;
      end
    end
    if ((state_q != IDLE) && (|ccw_wd_req_h)) begin
      err_set = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (|ccw_wd_req_h) begin
          req_d   = ccw_wd_req_h;
          pend_d  = ccw_wd_req_h;
          valid_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        for (int n = 0; n < NSLOT; n++) begin
          if (mb_hold_in_h[n] && pend_q[n] && req_q[n]) begin
            slot_d[n]  = wdata;
            valid_d[n] = 1'b1;
            pend_d[n]  = 1'b0;
          end
        end
        // The ready pulse is registered so it lines up with the first DRAIN cycle.
        if (pend_d == '0) begin
          state_d = DRAIN;
          rdy_l_d = 1'b0;
        end
      end
      DRAIN: begin
        if (chan_word_take_h && head_any) begin
          valid_d[head_idx] = 1'b0;
          if (valid_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Same-cycle set beats clear so no error event is ever lost.
    err_d = err_set | (err_q & ~chb_err_clr_h);
  end

  assign drain_vld        = (state_q == DRAIN) && head_any;
  assign chb_word_valid_h = drain_vld;
  assign chb_word_h       = drain_vld ? slot_q[head_idx] : '0;
  assign chb_wd_ready_l   = rdy_l_q;
  assign chb_busy_h       = (state_q != IDLE);
  assign chb_err_h        = err_q;

  always_comb begin
    chb_count_h = 3'd0;
    case (state_q)
      FILL:    chb_count_h = popcnt4(pend_q);
      DRAIN:   chb_count_h = popcnt4(valid_q);
      default: chb_count_h = 3'd0;
    endcase
  end

endmodule

// File: doc/chb_word_buf.md
CHB_WORD_BUF -- requirements
Module: chb_word_buf

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset; both are listed first below.
REQ-002 The port clk_ch_h SHALL be an input, 1 bit wide: the channel clock; every register samples on its rising edge.
REQ-003 The port ch_mr_reset_l SHALL be an input, 1 bit wide: the master reset, asynchronous and active-low.
REQ-004 The port ccw_wd_req_h SHALL be an input, 4 bits wide: the per-slot word requests wd0..wd3 issued by the CCW stage.
REQ-005 The port mb_hold_in_h SHALL be an input, 4 bits wide: a per-slot strobe meaning memory word n is on mb_data_h this cycle.
REQ-006 The port mb_data_h SHALL be an input, 36 bits wide: the memory buffer data, bit 0 = MSB (PDP-10 order).
REQ-007 The port ccl_zero_fill_h SHALL be an input, 1 bit wide: when high, a zero word is stored instead of mb_data_h.
REQ-008 The port chan_word_take_h SHALL be an input, 1 bit wide: the channel consumes the current head word.
REQ-009 The port chb_err_clr_h SHALL be an input, 1 bit wide: it clears the sticky error.
REQ-010 The port chb_word_h SHALL be an output, 36 bits wide: the head word presented to the channel.
REQ-011 The port chb_word_valid_h SHALL be an output, 1 bit wide: chb_word_h is valid.
REQ-012 The port chb_wd_ready_l SHALL be an output, 1 bit wide: an active-low one-cycle pulse meaning all requested words have arrived.
REQ-013 The port chb_count_h SHALL be an output, 3 bits wide: the number of words still to deliver (0..4).
REQ-014 The port chb_busy_h SHALL be an output, 1 bit wide: high whenever the state is not IDLE.
REQ-015 The port chb_err_h SHALL be an output, 1 bit wide: a sticky protocol-error flag.

Function
REQ-016 The block SHALL implement exactly three states: IDLE, FILL and DRAIN.
REQ-017 In IDLE with ccw_wd_req_h != 0, the block SHALL latch the request mask into req and pend, clear all slot-valid bits, and enter FILL on the next edge.
REQ-018 In IDLE with ccw_wd_req_h == 0, the block SHALL stay in IDLE.
REQ-019 In FILL, for each n with mb_hold_in_h[n]=1 and pend[n]=1, the block SHALL write slot n (zero if ccl_zero_fill_h, else mb_data_h), set valid[n] and clear pend[n]; several slots in the same cycle SHALL all be written.
REQ-020 When mb_hold_in_h[n]=1 while pend[n]=0 or the state is not FILL, the block SHALL not write the slot and SHALL set chb_err_h.
REQ-021 When pend becomes 0, the block SHALL enter DRAIN on the next edge and SHALL drive chb_wd_ready_l low for exactly that first DRAIN cycle.
REQ-022 In DRAIN, chb_word_h SHALL be the lowest-numbered slot with valid=1, and chb_word_valid_h SHALL be 1 while any valid bit is set.
REQ-023 In DRAIN, chan_word_take_h=1 SHALL clear the valid bit of the head slot at the edge, so the next slot is presented in the following cycle (one word per cycle maximum).
REQ-024 When the last valid slot is taken, the block SHALL enter IDLE on the same edge, and chb_word_valid_h SHALL be 0 in the next cycle.
REQ-025 chan_word_take_h SHALL be ignored when chb_word_valid_h=0 and SHALL not cause an error.
REQ-026 ccw_wd_req_h != 0 while not in IDLE SHALL be ignored and SHALL set chb_err_h.
REQ-027 chb_count_h SHALL equal popcount(pend) in FILL, popcount(valid) in DRAIN, and 0 in IDLE.
REQ-028 chb_err_h SHALL clear only on reset or chb_err_clr_h=1; when a set event and chb_err_clr_h occur in the same cycle, the set SHALL win.
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-030 Asserting ch_mr_reset_l low SHALL immediately force: state=IDLE, req/pend/valid=0, chb_word_h=0, chb_word_valid_h=0, chb_wd_ready_l=1, chb_count_h=0, chb_busy_h=0, chb_err_h=0.
REQ-031 A reset asserted during FILL or DRAIN SHALL discard all buffered data, and no chb_wd_ready_l pulse SHALL follow the reset.
REQ-032 Slot data registers need not be reset, but chb_word_h SHALL read 0 whenever chb_word_valid_h=0.

Structure
REQ-033 Package chb_pkg SHALL hold the state enum (IDLE, FILL, DRAIN), WORD_W=36 and NSLOT=4.
REQ-034 One sub-module, chb_slot_sel, SHALL implement a 4-bit lowest-set-bit priority encoder that outputs the index and an any-set flag.
REQ-035 The top level SHALL contain the state machine, the 4x36 slot registers and the error logic.

Verification
REQ-036 Scenario "full fill and drain": req=4'b1111; holds on slots 0,1,2,3 in successive cycles with data 1,2,3,4; take on every cycle -> chb_wd_ready_l pulses once, and words appear in the order 1,2,3,4 with count 4,3,2,1,0.
REQ-037 Scenario "sparse request": req=4'b0101; holds for slots 2 and 0 arrive in the same cycle -> both are written, DRAIN is entered in the next cycle, and the output is slot 0 then slot 2.
REQ-038 Scenario "zero fill": req=4'b0011 with ccl_zero_fill_h=1 and mb_data_h=36'o777777777777 -> both delivered words are 0.
REQ-039 Scenario "protocol errors": hold on slot 3 with req=4'b0001, then a new request during DRAIN -> chb_err_h=1 and the state/data are unaffected; chb_err_clr_h then clears the flag.
REQ-040 Scenario "reset mid-operation": reset in FILL after 2 of 4 words -> all outputs return to their reset values immediately; a fresh req=4'b1000 then completes normally.
REQ-041 Scenario "stalled channel": in DRAIN, take is held low for 10 cycles -> the head word and count are stable throughout and no error is raised.
